alu_seq_exec: RTL

Sequential execute unit that consumes the `AluControl_t` code produced by the ALU decoder, together with two operands, and returns a registered result plus a branch-taken flag over a valid/ready handshake. Shifts (SLL/SRL/SRA) run bit-serially, one bit per cycle, to save area on small FPGA targets. All other operations complete in one cycle. It sits in the execute stage of the multi-cycle/area-reduced core variant, between operand muxing and write-back.

---
 rtl/alu_seq_exec_pkg.sv | 56 +++++
 rtl/alu_serial_shifter.sv | 58 +++++
 rtl/alu_seq_exec.sv | 153 +++++++++++++++
 3 files changed

// File: rtl/alu_seq_exec_pkg.sv
// Shared execute-stage types: ALU operation codes, sequencer state, shift kinds.
// Latency: n/a (types and pure helper functions only).
// Backpressure: n/a.
package alu_seq_exec_pkg;

  // Operation codes produced by the ALU decoder; codes 18..31 are undefined.
  typedef enum logic [4:0] {
    ALU_ADD_ADDI = 5'd0,
    ALU_SUB      = 5'd1,
    ALU_XOR      = 5'd2,
    ALU_OR       = 5'd3,
    ALU_AND      = 5'd4,
    ALU_SLL      = 5'd5,
    ALU_SRL      = 5'd6,
    ALU_SRA      = 5'd7,
    ALU_SLT      = 5'd8,
    ALU_SLTU     = 5'd9,
    ALU_LUI      = 5'd10,
    ALU_AUIPC    = 5'd11,
    ALU_BEQ      = 5'd12,
    ALU_BNE      = 5'd13,
    ALU_BLT      = 5'd14,
    ALU_BGE      = 5'd15,
    ALU_BLTU     = 5'd16,
    ALU_BGEU     = 5'd17
  } AluControl_t;

  // Execute sequencer state, exported so debug/trace logic can decode it.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } alu_seq_state_t;

  // Direction/fill selection for the bit-serial shifter.
  typedef enum logic [1:0] {
    SHK_SLL = 2'd0,
    SHK_SRL = 2'd1,
    SHK_SRA = 2'd2
  } shift_kind_t;

  function automatic logic alu_is_shift(input AluControl_t c);
    return (c == ALU_SLL) || (c == ALU_SRL) || (c == ALU_SRA);
  endfunction

  function automatic shift_kind_t alu_shift_kind(input AluControl_t c);
    shift_kind_t k;
    case (c)
      ALU_SRL: k = SHK_SRL;
      ALU_SRA: k = SHK_SRA;
      default: k = SHK_SLL;
    endcase
    return k;
  endfunction

endpackage

// File: rtl/alu_serial_shifter.sv
// Bit-serial shifter: holds value/count, shifts one bit per step until count hits zero.
// Latency: one step per cycle; done pulses combinationally on the step that empties count.
// Backpressure: none; the owner controls pacing through load/step/clear.
module alu_serial_shifter
  import alu_seq_exec_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int SW   = $clog2(XLEN)
) (
  input  logic            clk,
  input  logic            resetn,
  input  logic            clear,
  input  logic            load,
  input  shift_kind_t     load_kind,
  input  logic [XLEN-1:0] load_val,
  input  logic [SW-1:0]   load_cnt,
  input  logic            step,
  output logic [XLEN-1:0] step_val,
  output logic            done
);

  logic [XLEN-1:0] value_q;
  logic [SW-1:0]   count_q;
  shift_kind_t     kind_q;

  // One-bit shift of the held value; SRA replicates the current top bit.
  always_comb begin
    step_val = value_q;
    case (kind_q)
      SHK_SLL: step_val = {value_q[XLEN-2:0], 1'b0};
      SHK_SRL: step_val = {1'b0, value_q[XLEN-1:1]};
      SHK_SRA: step_val = {value_q[XLEN-1], value_q[XLEN-1:1]};
      default: step_val = value_q;
    endcase
  end

  // The step that takes count from 1 to 0 produces the final value.
  assign done = step && (count_q == SW'(1));

  // Value/count registers: load on accept, step while shifting, clear on abort.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      value_q <= '0;
      count_q <= '0;
      kind_q  <= SHK_SLL;
    end else if (clear) begin
      count_q <= '0;
    end else if (load) begin
      value_q <= load_val;
      count_q <= load_cnt;
      kind_q  <= load_kind;
    end else if (step && (count_q != '0)) begin
      value_q <= step_val;
      count_q <= count_q - SW'(1);
    end
  end

endmodule

// File: rtl/alu_seq_exec.sv
// Sequential execute unit: single-cycle ALU/branch ops, bit-serial SLL/SRL/SRA.
// Latency: result valid 1 cycle after accept, or 1+shamt cycles for nonzero shifts.
// Backpressure: result held in DONE until out_ready; in_ready low from accept to handshake+1.
module alu_seq_exec
  import alu_seq_exec_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            resetn,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  AluControl_t     alu_ctrl,
  input  logic [XLEN-1:0] op_a,
  input  logic [XLEN-1:0] op_b,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result,
  output logic            branch_taken,
  output logic            busy
);

  localparam int SW = $clog2(XLEN);

  alu_seq_state_t  state_q;
  alu_seq_state_t  state_d;
  logic            accept;
  logic            is_shift;
  logic [SW-1:0]   shamt;
  logic [XLEN-1:0] alu_res;
  logic            alu_bt;
  logic            lt_s;
  logic            lt_u;
  logic            eq;
  logic            sh_load;
  logic            sh_step;
  logic            sh_done;
  logic [XLEN-1:0] sh_val;
  logic [XLEN-1:0] result_q;
  logic            bt_q;
  logic            out_valid_q;

  assign in_ready = (state_q == IDLE) && !flush;
  assign accept   = in_valid && in_ready;
  assign busy     = (state_q != IDLE);
  assign is_shift = alu_is_shift(alu_ctrl);
  assign shamt    = op_b[SW-1:0];

  assign lt_s = $signed(op_a) < $signed(op_b);
  assign lt_u = op_a < op_b;
  assign eq   = op_a == op_b;

  // Single-cycle datapath; shifts yield op_a here, which is the shamt==0 answer.
  always_comb begin
    alu_res = op_a + op_b;
    alu_bt  = 1'b0;
    case (alu_ctrl)
      ALU_ADD_ADDI, ALU_AUIPC: alu_res = op_a + op_b;
      ALU_SUB:  alu_res = op_a - op_b;
      ALU_XOR:  alu_res = op_a ^ op_b;
      ALU_OR:   alu_res = op_a | op_b;
      ALU_AND:  alu_res = op_a & op_b;
      ALU_LUI:  alu_res = op_b;
      ALU_SLT:  alu_res = {{(XLEN-1){1'b0}}, lt_s};
      ALU_SLTU: alu_res = {{(XLEN-1){1'b0}}, lt_u};
      ALU_SLL, ALU_SRL, ALU_SRA: alu_res = op_a;
      ALU_BEQ:  begin alu_res = '0; alu_bt = eq;    end
      ALU_BNE:  begin alu_res = '0; alu_bt = !eq;   end
      ALU_BLT:  begin alu_res = '0; alu_bt = lt_s;  end
      ALU_BGE:  begin alu_res = '0; alu_bt = !lt_s; end
      ALU_BLTU: begin alu_res = '0; alu_bt = lt_u;  end
      ALU_BGEU: begin alu_res = '0; alu_bt = !lt_u; end
      default:  begin alu_res = op_a + op_b; alu_bt = 1'b0; end
    endcase
  end

  alu_serial_shifter #(
    .XLEN (XLEN),
    .SW   (SW)
  ) u_shifter (
    .clk       (clk),
    .resetn    (resetn),
    .clear     (flush),
    .load      (sh_load),
    .load_kind (alu_shift_kind(alu_ctrl)),
    .load_val  (op_a),
    .load_cnt  (shamt),
    .step      (sh_step),
    .step_val  (sh_val),
    .done      (sh_done)
  );

  // Next-state and shifter controls; flush aborts SHIFT/DONE ahead of everything else.
  always_comb begin
    state_d = state_q;
    sh_load = 1'b0;
    sh_step = 1'b0;
    case (state_q)
      IDLE: begin
        if (accept) begin
          if (is_shift && (shamt != '0)) begin
            sh_load = 1'b1;
            state_d = SHIFT;
          end else begin
            state_d = DONE;
          end
        end
      end
      SHIFT: begin
        if (flush) begin
          state_d = IDLE;
        end else begin
          sh_step = 1'b1;
          if (sh_done) state_d = DONE;
        end
      end
      DONE: begin
        if (flush || out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state_q <= IDLE;
    else         state_q <= state_d;
  end

  // Output registers: capture at accept or at the final shift step, hold otherwise.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      result_q    <= '0;
      bt_q        <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      out_valid_q <= (state_d == DONE);
      if (accept) begin
        result_q <= alu_res;
        bt_q     <= alu_bt;
      end else if ((state_q == SHIFT) && !flush && sh_done) begin
        result_q <= sh_val;
        bt_q     <= 1'b0;
      end
    end
  end

  assign out_valid    = out_valid_q;
  assign result       = result_q;
  assign branch_taken = bt_q;

endmodule
